mem_bank_2rw_arb: RTL and testbench



---
 rtl/mem_bank_2rw_arb.sv | 112 +++++++++++
 tb/tb_mem_bank_2rw_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_2rw_arb.sv
// mem_bank_2rw_arb: round-robin arbiter sharing a 2-port register bank among NREQ requesters,
// two grants per cycle with same-address write hazards blocked, registered responses.
module mem_bank_2rw_arb #(
    parameter int NREQ = 4,
    parameter int AW   = 2,
    parameter int DW   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_wmode,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [NREQ*DW-1:0] rsp_rdata,
    output logic               RW0_en,
    output logic               RW0_wmode,
    output logic [AW-1:0]      RW0_addr,
    output logic [DW-1:0]      RW0_wdata,
    input  logic [DW-1:0]      RW0_rdata,
    output logic               RW1_en,
    output logic               RW1_wmode,
    output logic [AW-1:0]      RW1_addr,
    output logic [DW-1:0]      RW1_wdata,
    input  logic [DW-1:0]      RW1_rdata
);
    localparam int PW = $clog2(NREQ);
    localparam logic [PW:0] NQ = (PW+1)'(NREQ);
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    logic [PW-1:0]      r_rr_ptr;
    logic [NREQ-1:0]    r_rsp_valid;
    logic [NREQ*DW-1:0] r_rsp_rdata;
    logic [PW-1:0]      w_g0, w_g1, w_last;
    logic               w_f0, w_f1;
    logic [NREQ-1:0]    w_oh0, w_oh1;
    logic [AW-1:0]      w_addr [NREQ];
    logic [DW-1:0]      w_wdata [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_addr[i]  = req_addr[i*AW +: AW];
        assign w_wdata[i] = req_wdata[i*DW +: DW];
    end

    // Port 1 takes the next requester in scan order that cannot collide with port 0's access
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        logic          cf;
        w_f0 = 1'b0;
        w_f1 = 1'b0;
        w_g0 = '0;
        w_g1 = '0;
        sum  = '0;
        idx  = '0;
        cf   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, r_rr_ptr} + (PW+1)'(k);
            idx = PW'(sum >= NQ ? sum - NQ : sum);
            cf  = w_addr[idx] == w_addr[w_g0] && (req_wmode[idx] || req_wmode[w_g0]);
            if (req_valid[idx] && !rst) begin
                if (!w_f0) begin
                    w_f0 = 1'b1;
                    w_g0 = idx;
                end else if (!w_f1 && !cf) begin
                    w_f1 = 1'b1;
                    w_g1 = idx;
                end
            end
        end
    end

    always_comb begin
        w_oh0 = '0;
        w_oh1 = '0;
        w_oh0[w_g0] = w_f0;
        w_oh1[w_g1] = w_f1;
    end

    assign req_ready = w_oh0 | w_oh1;
    assign w_last    = w_f1 ? w_g1 : w_g0;

    // Idle ports drive zeros: the bank writes on wmode alone
    assign RW0_en    = w_f0;
    assign RW0_wmode = w_f0 & req_wmode[w_g0];
    assign RW0_addr  = w_f0 ? w_addr[w_g0] : '0;
    assign RW0_wdata = w_f0 ? w_wdata[w_g0] : '0;
    assign RW1_en    = w_f1;
    assign RW1_wmode = w_f1 & req_wmode[w_g1];
    assign RW1_addr  = w_f1 ? w_addr[w_g1] : '0;
    assign RW1_wdata = w_f1 ? w_wdata[w_g1] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= req_ready;
            if (w_f0)
                r_rr_ptr <= w_last == LAST ? '0 : w_last + 1'b1;
            for (int i = 0; i < NREQ; i++)
                if (req_ready[i])
                    r_rsp_rdata[i*DW +: DW] <= w_oh0[i] ? (RW0_wmode ? '0 : RW0_rdata)
                                                        : (RW1_wmode ? '0 : RW1_rdata);
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_mem_bank_2rw_arb.sv
// tb_mem_bank_2rw_arb: directed vector table, reset sequences and randomized traffic
// against a queue-based arbitration model with a shadow copy of the bank.
module tb_mem_bank_2rw_arb;
    localparam int N = 4, AW = 2, DW = 64;

    logic clk = 1'b0, rst = 1'b1;
    logic [N-1:0] req_valid = '0, req_wmode = '0, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0, rsp_rdata;
    logic RW0_en, RW0_wmode, RW1_en, RW1_wmode;
    logic [AW-1:0] RW0_addr, RW1_addr;
    logic [DW-1:0] RW0_wdata, RW0_rdata, RW1_wdata, RW1_rdata;

    logic [DW-1:0] bank [4] = '{default: '0};
    logic [DW-1:0] ref_mem [4] = '{default: '0};
    logic [255:0] m_rsp = '0;
    int m_ptr = 0;
    int checks = 0, errors = 0;

    logic [3:0] tv, twm;
    logic [1:0] tad [4];
    logic [63:0] twd [4];

    typedef struct packed {
        logic [3:0]   v, wm;
        logic [7:0]   ad;
        logic [255:0] wd;
        logic [3:0]   rdy;
        logic [255:0] rd;
    } vec_t;
    vec_t tbl [16];

    mem_bank_2rw_arb #(.NREQ(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wmode(req_wmode),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .RW0_en(RW0_en), .RW0_wmode(RW0_wmode), .RW0_addr(RW0_addr),
        .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata),
        .RW1_en(RW1_en), .RW1_wmode(RW1_wmode), .RW1_addr(RW1_addr),
        .RW1_wdata(RW1_wdata), .RW1_rdata(RW1_rdata)
    );

    always #5 clk = ~clk;

    assign RW0_rdata = bank[RW0_addr];
    assign RW1_rdata = bank[RW1_addr];
    always @(posedge clk) begin
        if (RW0_wmode) bank[RW0_addr] <= RW0_wdata;
        if (RW1_wmode) bank[RW1_addr] <= RW1_wdata;
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic drive();
        req_valid = tv;
        req_wmode = twm;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*2 +: 2]   = tad[i];
            req_wdata[i*64 +: 64] = twd[i];
        end
    endtask

    // One arbitration cycle: grants and ports mid-cycle, registered response after the edge
    task automatic cyc(input logic [3:0] er, input logic [255:0] erd, input bit cp,
                       input logic [67:0] ep0, input logic [67:0] ep1);
        drive();
        @(negedge clk);
        chk("req_ready", 256'(req_ready), 256'(er));
        if (cp) begin
            chk("port0", 256'({RW0_en, RW0_wmode, RW0_addr, RW0_wdata}), 256'(ep0));
            chk("port1", 256'({RW1_en, RW1_wmode, RW1_addr, RW1_wdata}), 256'(ep1));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (er[i]) begin
                m_rsp[i*64 +: 64] = erd[i*64 +: 64];
                if (twm[i]) ref_mem[tad[i]] = twd[i];
            end
        chk("rsp_valid", 256'(rsp_valid), 256'(er));
        chk("rsp_rdata", rsp_rdata, m_rsp);
    endtask

    task automatic model(output int g0, output int g1);
        int ord[$];
        int j;
        g0 = -1;
        g1 = -1;
        for (int k = 0; k < 4; k++) begin
            j = (m_ptr + k) % 4;
            if (tv[j]) ord.push_back(j);
        end
        if (ord.size() > 0) begin
            g0 = ord.pop_front();
            foreach (ord[q])
                if (g1 < 0 && !(tad[ord[q]] == tad[g0] && (twm[ord[q]] || twm[g0])))
                    g1 = ord[q];
        end
    endtask

    initial begin
        int g0, g1;
        logic [3:0] er;
        logic [255:0] erd;
        logic [67:0] ep0, ep1;

        tbl[0]  = '{v:4'b0011, wm:4'b0011, ad:8'b00_00_10_01, wd:{128'd0, 64'h5555, 64'hAAAA}, rdy:4'b0011, rd:256'd0};
        tbl[1]  = '{v:4'b1100, wm:4'b0000, ad:8'b10_01_00_00, wd:256'd0, rdy:4'b1100, rd:{64'h5555, 64'hAAAA, 128'd0}};
        tbl[2]  = '{v:4'b0011, wm:4'b0011, ad:8'b00_00_11_11, wd:{128'd0, 64'h2222, 64'h1111}, rdy:4'b0001, rd:256'd0};
        tbl[3]  = '{v:4'b0010, wm:4'b0010, ad:8'b00_00_11_00, wd:{128'd0, 64'h2222, 64'd0}, rdy:4'b0010, rd:256'd0};
        tbl[4]  = '{v:4'b0100, wm:4'b0000, ad:8'b00_11_00_00, wd:256'd0, rdy:4'b0100, rd:{64'd0, 64'h2222, 128'd0}};
        tbl[5]  = '{v:4'b0001, wm:4'b0001, ad:8'b00_00_00_00, wd:{192'd0, 64'hC0FFEE}, rdy:4'b0001, rd:256'd0};
        tbl[6]  = '{v:4'b1100, wm:4'b0000, ad:8'b00_00_00_00, wd:256'd0, rdy:4'b1100, rd:{64'hC0FFEE, 64'hC0FFEE, 128'd0}};
        tbl[7]  = '{v:4'b1111, wm:4'b0000, ad:8'b11_10_01_00, wd:256'd0, rdy:4'b0011, rd:{128'd0, 64'hAAAA, 64'hC0FFEE}};
        tbl[8]  = '{v:4'b1111, wm:4'b0000, ad:8'b11_10_01_00, wd:256'd0, rdy:4'b1100, rd:{64'h2222, 64'h5555, 128'd0}};
        tbl[9]  = '{v:4'b1111, wm:4'b0000, ad:8'b11_10_01_00, wd:256'd0, rdy:4'b0011, rd:{128'd0, 64'hAAAA, 64'hC0FFEE}};
        tbl[10] = '{v:4'b0000, wm:4'b0000, ad:8'b00_00_00_00, wd:256'd0, rdy:4'b0000, rd:256'd0};
        tbl[11] = '{v:4'b1101, wm:4'b1100, ad:8'b01_01_00_10, wd:{64'h88, 64'h77, 128'd0}, rdy:4'b0101, rd:{192'd0, 64'h5555}};
        tbl[12] = '{v:4'b1000, wm:4'b1000, ad:8'b01_00_00_00, wd:{64'h88, 192'd0}, rdy:4'b1000, rd:256'd0};
        tbl[13] = '{v:4'b0011, wm:4'b0010, ad:8'b00_00_01_01, wd:{128'd0, 64'h99, 64'd0}, rdy:4'b0001, rd:{192'd0, 64'h88}};
        tbl[14] = '{v:4'b0010, wm:4'b0010, ad:8'b00_00_01_00, wd:{128'd0, 64'h99, 64'd0}, rdy:4'b0010, rd:256'd0};
        tbl[15] = '{v:4'b0001, wm:4'b0000, ad:8'b00_00_00_01, wd:256'd0, rdy:4'b0001, rd:{192'd0, 64'h99}};

        tv = 4'hF;
        twm = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tad[i] = 2'd1;
            twd[i] = {$urandom, $urandom};
        end
        drive();
        #3;
        chk("rst_idle", 256'({RW0_en, RW0_wmode, RW1_en, RW1_wmode, req_ready, rsp_valid}), 256'd0);
        @(posedge clk);
        #1;
        chk("rst_idle_edge", 256'({RW0_en, RW0_wmode, RW1_en, RW1_wmode, req_ready, rsp_valid}), 256'd0);
        rst = 1'b0;
        tv = '0;
        cyc(4'b0000, 256'd0, 1'b1, 68'd0, 68'd0);

        for (int r = 0; r < 16; r++) begin
            tv  = tbl[r].v;
            twm = tbl[r].wm;
            for (int i = 0; i < 4; i++) begin
                tad[i] = tbl[r].ad[i*2 +: 2];
                twd[i] = tbl[r].wd[i*64 +: 64];
            end
            cyc(tbl[r].rdy, tbl[r].rd, 1'b0, 68'd0, 68'd0);
        end

        tv = 4'hF;
        twm = 4'h0;
        for (int i = 0; i < 4; i++) tad[i] = 2'(i);
        cyc(4'b0110, {64'd0, 64'h5555, 64'h99, 64'd0}, 1'b0, 68'd0, 68'd0);
        #2;
        rst = 1'b1;
        #1;
        m_rsp = '0;
        chk("async_rst_rsp", 256'({rsp_valid, req_ready, RW0_en, RW1_en}), 256'd0);
        chk("async_rst_rdata", rsp_rdata, m_rsp);
        rst = 1'b0;
        cyc(4'b0011, {128'd0, 64'h99, 64'hC0FFEE}, 1'b0, 68'd0, 68'd0);

        #1;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m_rsp = '0;
        m_ptr = 0;
        tv = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++)
                if (!tv[i] && $urandom_range(2) != 0) begin
                    tv[i]  = 1'b1;
                    twm[i] = 1'($urandom_range(1));
                    tad[i] = 2'($urandom_range(3));
                    twd[i] = {$urandom, $urandom};
                end
            model(g0, g1);
            er = '0;
            erd = '0;
            ep0 = '0;
            ep1 = '0;
            if (g0 >= 0) begin
                er[g0] = 1'b1;
                erd[g0*64 +: 64] = twm[g0] ? 64'd0 : ref_mem[tad[g0]];
                ep0 = {1'b1, twm[g0], tad[g0], twd[g0]};
            end
            if (g1 >= 0) begin
                er[g1] = 1'b1;
                erd[g1*64 +: 64] = twm[g1] ? 64'd0 : ref_mem[tad[g1]];
                ep1 = {1'b1, twm[g1], tad[g1], twd[g1]};
            end
            cyc(er, erd, 1'b1, ep0, ep1);
            if (g0 >= 0) begin
                m_ptr = ((g1 >= 0 ? g1 : g0) + 1) % 4;
                tv[g0] = 1'b0;
                if (g1 >= 0) tv[g1] = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
